// File: rtl/tmp8_pkg.sv
// Shared definitions for the 10-bit program counter: address width,
// default reset vector, operation encoding and a wrap-around increment helper.
package tmp8_pkg;

    localparam int ADDR_W  = 10;
    localparam int DEPTH_W = 4;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_VECTOR = 10'h000;

    typedef enum logic [2:0] {
        PC_HOLD = 3'd0,
        PC_INC  = 3'd1,
        PC_JUMP = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4
    } pc_op_e;

    // Next sequential address; the natural 10-bit overflow gives the 3FF->000 wrap.
    function automatic logic [ADDR_W-1:0] pc_plus_one(input logic [ADDR_W-1:0] pc_val);
        return pc_val + 10'd1;
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses. Storage is not reset; only the occupancy count
// and the full/empty flags are. Pop wins over push if both are requested.
module return_stack
    import tmp8_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int ADDR_W      = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [ADDR_W-1:0]  din,
    output logic [ADDR_W-1:0]  top,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    logic [ADDR_W-1:0]  mem_q [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;
    logic               full_q;
    logic               full_d;
    logic               empty_q;
    logic               empty_d;
    logic               do_push_s;
    logic               do_pop_s;
    logic [IDX_W-1:0]   wr_idx_s;
    logic [IDX_W-1:0]   rd_idx_s;

    assign do_pop_s  = pop && !empty_q;
    assign do_push_s = push && !pop && !full_q;
    assign wr_idx_s  = depth_q[IDX_W-1:0];
    assign rd_idx_s  = IDX_W'(depth_q - 4'd1);

    // Next occupancy and the flags that track it, so both stay in step.
    always_comb begin
        depth_d = depth_q;
        if (do_pop_s) begin
            depth_d = depth_q - 4'd1;
        end else if (do_push_s) begin
            depth_d = depth_q + 4'd1;
        end else begin
            depth_d = depth_q;
        end
        full_d  = (depth_d == DEPTH_MAX);
        empty_d = (depth_d == 4'd0);
    end

    // Occupancy and flag registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= 4'd0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            depth_q <= depth_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Entry storage: written on push, never reset so it can map to LUT RAM.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_idx_s] <= din;
        end
    end

    assign top   = mem_q[rd_idx_s];
    assign depth = depth_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/program_counter_10bit.sv
// 10-bit program counter with jump, call/return via a small return stack,
// and sticky overflow/underflow error flags. All outputs are registered.
module program_counter_10bit
    import tmp8_pkg::*;
#(
    parameter logic [9:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int         STACK_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        jump,
    input  logic        call,
    input  logic        ret,
    input  logic [9:0]  jump_addr,
    output logic [9:0]  pc,
    output logic [3:0]  depth,
    output logic        stk_full,
    output logic        stk_empty,
    output logic        err_ovf,
    output logic        err_unf
);

    pc_op_e              op_s;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic                err_ovf_q;
    logic                err_ovf_d;
    logic                err_unf_q;
    logic                err_unf_d;
    logic                push_s;
    logic                pop_s;
    logic [ADDR_W-1:0]   ret_addr_s;
    logic [ADDR_W-1:0]   top_s;
    logic                full_s;
    logic                empty_s;
    logic [DEPTH_W-1:0]  depth_s;

    assign ret_addr_s = pc_plus_one(pc_q);

    // Priority decode: ret beats call beats jump beats increment; en gates all.
    always_comb begin
        op_s = PC_HOLD;
        if (!en) begin
            op_s = PC_HOLD;
        end else if (ret) begin
            op_s = PC_RET;
        end else if (call) begin
            op_s = PC_CALL;
        end else if (jump) begin
            op_s = PC_JUMP;
        end else begin
            op_s = PC_INC;
        end
    end

    // Next pc, stack requests and error flags for the decoded operation.
    always_comb begin
        pc_d      = pc_q;
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        case (op_s)
            PC_INC: begin
                pc_d = ret_addr_s;
            end
            PC_JUMP: begin
                pc_d = jump_addr;
            end
            PC_CALL: begin
                if (full_s) begin
                    err_ovf_d = 1'b1;
                end else begin
                    pc_d   = jump_addr;
                    push_s = 1'b1;
                end
            end
            PC_RET: begin
                if (empty_s) begin
                    err_unf_d = 1'b1;
                end else begin
                    pc_d  = top_s;
                    pop_s = 1'b1;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // pc and sticky error registers; reset overrides every operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_VECTOR;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    return_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .ADDR_W      (ADDR_W)
    ) u_return_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (ret_addr_s),
        .top   (top_s),
        .depth (depth_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign pc        = pc_q;
    assign depth     = depth_s;
    assign stk_full  = full_s;
    assign stk_empty = empty_s;
    assign err_ovf   = err_ovf_q;
    assign err_unf   = err_unf_q;

endmodule

// File: tb/tb_program_counter_10bit.sv
// Directed, table-driven bench for program_counter_10bit (RESET_VECTOR=10'h010).
module tb_program_counter_10bit;

    logic       clk;
    logic       reset;
    logic       en;
    logic       jump;
    logic       call;
    logic       ret;
    logic [9:0] jump_addr;
    logic [9:0] pc;
    logic [3:0] depth;
    logic       stk_full;
    logic       stk_empty;
    logic       err_ovf;
    logic       err_unf;

    int checks;
    int errors;

    typedef struct {
        logic       rst;
        logic       en;
        logic       jmp;
        logic       cal;
        logic       rt;
        logic [9:0] addr;
        logic [9:0] e_pc;
        logic [3:0] e_depth;
        logic       e_full;
        logic       e_empty;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    vec_t vecs[$];

    program_counter_10bit #(
        .RESET_VECTOR (10'h010),
        .STACK_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .jump_addr (jump_addr),
        .pc        (pc),
        .depth     (depth),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic j, input logic c,
                       input logic t, input logic [9:0] a, input logic [9:0] p,
                       input logic [3:0] d, input logic f, input logic em,
                       input logic o, input logic u);
        vec_t v;
        v.rst = r; v.en = e; v.jmp = j; v.cal = c; v.rt = t; v.addr = a;
        v.e_pc = p; v.e_depth = d; v.e_full = f; v.e_empty = em;
        v.e_ovf = o; v.e_unf = u;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic j, input logic c,
                         input logic t, input logic [9:0] a);
        reset = r; en = e; jump = j; call = c; ret = t; jump_addr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input int idx, input logic [9:0] p, input logic [3:0] d,
                           input logic f, input logic em, input logic o, input logic u);
        chk("pc",        idx, {6'd0, pc},        {6'd0, p});
        chk("depth",     idx, {12'd0, depth},    {12'd0, d});
        chk("stk_full",  idx, {15'd0, stk_full}, {15'd0, f});
        chk("stk_empty", idx, {15'd0, stk_empty},{15'd0, em});
        chk("err_ovf",   idx, {15'd0, err_ovf},  {15'd0, o});
        chk("err_unf",   idx, {15'd0, err_unf},  {15'd0, u});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; en = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
        jump_addr = 10'h000;

        //   rst  en   jmp  cal  ret  addr     pc       dep   full empty ovf  unf
        add(1'b1,1'b0,1'b0,1'b0,1'b0,10'h000, 10'h010, 4'd0, 1'b0,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0,10'h000, 10'h011, 4'd0, 1'b0,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0,10'h000, 10'h012, 4'd0, 1'b0,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0,10'h000, 10'h013, 4'd0, 1'b0,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,1'b0,10'h3FE, 10'h3FE, 4'd0, 1'b0,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0,10'h000, 10'h3FF, 4'd0, 1'b0,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0,10'h000, 10'h000, 4'd0, 1'b0,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,1'b0,10'h020, 10'h020, 4'd0, 1'b0,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b1,1'b0,10'h100, 10'h100, 4'd1, 1'b0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b1,1'b0,10'h200, 10'h200, 4'd2, 1'b0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b1,10'h000, 10'h101, 4'd1, 1'b0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b1,10'h000, 10'h021, 4'd0, 1'b0,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b1,10'h000, 10'h021, 4'd0, 1'b0,1'b1,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,1'b1,1'b0,10'h040, 10'h040, 4'd1, 1'b0,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,1'b1,1'b1,10'h3AA, 10'h022, 4'd0, 1'b0,1'b1,1'b0,1'b1);
        add(1'b1,1'b0,1'b0,1'b0,1'b0,10'h000, 10'h010, 4'd0, 1'b0,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b1,1'b0,10'h100, 10'h100, 4'd1, 1'b0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b1,1'b0,10'h180, 10'h180, 4'd2, 1'b0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b1,1'b0,10'h200, 10'h200, 4'd3, 1'b0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b1,1'b0,10'h280, 10'h280, 4'd4, 1'b1,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b1,1'b0,10'h300, 10'h280, 4'd4, 1'b1,1'b0,1'b1,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b1,10'h000, 10'h201, 4'd3, 1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b1,10'h000, 10'h181, 4'd2, 1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b1,10'h000, 10'h101, 4'd1, 1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b1,10'h000, 10'h011, 4'd0, 1'b0,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,1'b1,1'b0,1'b0,10'h3C0, 10'h011, 4'd0, 1'b0,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,1'b0,1'b0,1'b1,10'h000, 10'h011, 4'd0, 1'b0,1'b1,1'b1,1'b0);
        add(1'b0,1'b1,1'b0,1'b1,1'b0,10'h050, 10'h050, 4'd1, 1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b1,1'b0,1'b1,1'b0,10'h060, 10'h060, 4'd2, 1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,1'b1,1'b1,1'b1,10'h3FF, 10'h060, 4'd2, 1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b1,1'b0,1'b1,1'b0,10'h070, 10'h070, 4'd3, 1'b0,1'b0,1'b1,1'b0);
        add(1'b1,1'b1,1'b0,1'b1,1'b0,10'h3FF, 10'h010, 4'd0, 1'b0,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0,10'h000, 10'h011, 4'd0, 1'b0,1'b1,1'b0,1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].jmp, vecs[i].cal, vecs[i].rt,
                  vecs[i].addr);
            chk_all(i, vecs[i].e_pc, vecs[i].e_depth, vecs[i].e_full,
                    vecs[i].e_empty, vecs[i].e_ovf, vecs[i].e_unf);
        end

        // Interleaved call/ret: the LIFO must hand back the most recent return address.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        chk_all(100, 10'h010, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h100);
        chk_all(101, 10'h100, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h200);
        chk_all(102, 10'h200, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000);
        chk_all(103, 10'h101, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h300);
        chk_all(104, 10'h300, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000);
        chk_all(105, 10'h102, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000);
        chk_all(106, 10'h011, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Outputs must not react to inputs before the next rising edge.
        en = 1'b1; jump = 1'b1; call = 1'b0; ret = 1'b0; jump_addr = 10'h2AA;
        #2;
        chk("pc_pre_edge", 107, {6'd0, pc}, {6'd0, 10'h011});
        @(posedge clk);
        #1;
        chk("pc_post_edge", 108, {6'd0, pc}, {6'd0, 10'h2AA});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
